// File: rtl/u74hc165.sv
// 74HC165 8-bit parallel-in/serial-out shift register, board-level model.
// The device clock pin is sampled as data and edge-detected on the simulation clock.
module u74hc165 #(
    parameter logic [7:0] ic = 8'h00
) (
    input  logic clk,
    input  logic rst,
    input  logic sh_ld,
    input  logic cp,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic h,
    output logic qh_n,
    input  logic gnd,
    output logic qh,
    input  logic ser,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic clk_inh,
    input  logic vcc
);

    logic [7:0] sr_reg;
    logic [7:0] sr_next;
    logic [7:0] shifted;
    logic [7:0] par;
    logic       gclk;
    logic       gclk_reg;
    logic       rise;
    logic       unused_supply;

    // Supplies are present only to keep the pin order; they carry no function.
    assign unused_supply = gnd ^ vcc;

    assign par  = {h, g, f, e, d, c, b, a};
    assign gclk = cp | clk_inh;
    assign rise = gclk & ~gclk_reg;

    assign shifted[0] = ser;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_shift
            assign shifted[gi] = sr_reg[gi-1];
        end
    endgenerate

    // Load is level-sensitive and swallows any clock edge seen while it is low.
    always_comb begin
        sr_next = sr_reg;
        if (!sh_ld) begin
            sr_next = par;
        end else if (rise) begin
            sr_next = shifted;
        end
    end

    always_ff @(posedge clk) begin
        gclk_reg <= gclk;
        if (!rst) begin
            sr_reg <= ic;
        end else begin
            sr_reg <= sr_next;
        end
    end

    assign qh   = sr_reg[7];
    assign qh_n = ~sr_reg[7];

endmodule
